// File: rtl/cnn_act_pkg.sv
// Shared definitions for the CNN activation unit: mode encoding, the sigmoid
// breakpoint table (Q0.16) and fixed shift amounts.
package cnn_act_pkg;

    typedef enum logic [1:0] {
        MODE_SIGMOID = 2'd0,
        MODE_TANH    = 2'd1,
        MODE_RELU    = 2'd2,
        MODE_LEAKY   = 2'd3
    } act_mode_e;

    localparam int COEF_FRAC   = 16;
    localparam int LEAKY_SHIFT = 3;
    localparam int S_ENTRIES   = 9;

    // sigma(k) for k = 0..8 in Q0.16; indices past 8 repeat the last point so
    // the interpolation slope is zero in the saturated region.
    function automatic logic [15:0] sig_point(input logic [3:0] k);
        logic [15:0] s;
        case (k)
            4'd0:    s = 16'd32768;
            4'd1:    s = 16'd47911;
            4'd2:    s = 16'd57724;
            4'd3:    s = 16'd62428;
            4'd4:    s = 16'd64357;
            4'd5:    s = 16'd65097;
            4'd6:    s = 16'd65374;
            4'd7:    s = 16'd65476;
            default: s = 16'd65514;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/cnn_act_lane.sv
// One lane of the activation datapath: prep, table lookup, interpolation and
// post-processing, four registers deep, all advancing together on en.
module cnn_act_lane
    import cnn_act_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int FRAC_BITS  = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en,
    input  logic [1:0]            mode,
    input  logic [DATA_WIDTH-1:0] x,
    output logic [DATA_WIDTH-1:0] y
);

    localparam int W     = DATA_WIDTH;
    localparam int SHIFT = COEF_FRAC - FRAC_BITS;
    localparam logic signed [19:0] RND_V = (SHIFT > 0) ? 20'(1 << (SHIFT - 1)) : 20'sd0;

    // S1 combinational prep
    logic [W-1:0]  x_t;
    logic [W-1:0]  xs;
    logic [W-1:0]  a;
    logic          sat;
    logic [3:0]    k_n;
    logic [15:0]   f_n;
    logic [W-1:0]  byp_n;

    always_comb begin
        // tanh(x) = 2*sigma(2x) - 1, so the tanh path feeds a doubled, saturated input
        if (x[W-1] != x[W-2]) begin
            x_t = x[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
        end else begin
            x_t = {x[W-2:0], 1'b0};
        end
        xs    = (mode == MODE_TANH) ? x_t : x;
        a     = x[W-1] ? (-xs) : xs;
        sat   = (a >> FRAC_BITS) > W'(7);
        k_n   = sat ? 4'd8 : a[FRAC_BITS+3:FRAC_BITS];
        f_n   = sat ? 16'd0 : (16'(a[FRAC_BITS-1:0]) << SHIFT);
        byp_n = x;
        if (x[W-1]) begin
            byp_n = (mode == MODE_LEAKY) ? W'($signed(x) >>> LEAKY_SHIFT) : '0;
        end
    end

    act_mode_e     mode1, mode2, mode3;
    logic          neg1, neg2, neg3;
    logic [3:0]    k1;
    logic [15:0]   f1, f2;
    logic [15:0]   s_lo2, s_hi2;
    logic [16:0]   y3;
    logic [W-1:0]  byp1, byp2, byp3;

    // S4 combinational post: mirror for negative inputs, rescale for tanh
    logic [16:0]        yp;
    logic signed [19:0] ys;
    logic signed [19:0] v;

    always_comb begin
        yp = neg3 ? (17'h10000 - y3) : y3;
        ys = $signed({3'b000, yp});
        v  = (mode3 == MODE_TANH) ? (ys + ys - 20'sd65536) : ys;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            mode1 <= MODE_SIGMOID;
            mode2 <= MODE_SIGMOID;
            mode3 <= MODE_SIGMOID;
            neg1  <= 1'b0;
            neg2  <= 1'b0;
            neg3  <= 1'b0;
            k1    <= '0;
            f1    <= '0;
            f2    <= '0;
            s_lo2 <= '0;
            s_hi2 <= '0;
            y3    <= '0;
            byp1  <= '0;
            byp2  <= '0;
            byp3  <= '0;
            y     <= '0;
        end else if (en) begin
            mode1 <= act_mode_e'(mode);
            neg1  <= x[W-1];
            k1    <= k_n;
            f1    <= f_n;
            byp1  <= byp_n;

            mode2 <= mode1;
            neg2  <= neg1;
            f2    <= f1;
            s_lo2 <= sig_point(k1);
            s_hi2 <= sig_point(k1 + 4'd1);
            byp2  <= byp1;

            mode3 <= mode2;
            neg3  <= neg2;
            byp3  <= byp2;
            y3    <= 17'(s_lo2) +
                     17'(({16'b0, s_hi2 - s_lo2} * {16'b0, f2}) >> COEF_FRAC);

            if (mode3 == MODE_RELU || mode3 == MODE_LEAKY) begin
                y <= byp3;
            end else begin
                y <= W'((v + RND_V) >>> SHIFT);
            end
        end
    end

endmodule

// File: rtl/cnn_activation.sv
// Multi-lane activation unit: LANES datapath copies behind a shared valid
// pipeline, global-stall handshake, per-frame mode latch and done pulse.
module cnn_activation
    import cnn_act_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int FRAC_BITS  = 8,
    parameter int LANES      = 4,
    parameter int FRAME_LEN  = 1024
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [1:0]                  mode,
    input  logic                        valid_in,
    output logic                        ready_in,
    input  logic [LANES*DATA_WIDTH-1:0] in,
    output logic                        valid_out,
    input  logic                        ready_out,
    output logic [LANES*DATA_WIDTH-1:0] out,
    output logic                        done
);

    localparam int CW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam logic [CW-1:0] LAST = CW'(FRAME_LEN - 1);

    logic          en;
    logic          accept;
    logic          emit;
    logic [2:0]    vpipe;
    logic [CW-1:0] in_cnt;
    logic [CW-1:0] out_cnt;
    logic [1:0]    frame_mode;
    logic [1:0]    beat_mode;

    assign en       = !valid_out || ready_out;
    assign ready_in = en;
    assign accept   = valid_in && en;
    assign emit     = valid_out && ready_out;

    // The first beat of a frame uses the live mode; the rest use the latched one.
    assign beat_mode = (in_cnt == '0) ? mode : frame_mode;

    always_ff @(posedge clk) begin
        if (!reset) begin
            vpipe      <= '0;
            valid_out  <= 1'b0;
            done       <= 1'b0;
            in_cnt     <= '0;
            out_cnt    <= '0;
            frame_mode <= MODE_SIGMOID;
        end else begin
            done <= 1'b0;
            if (en) begin
                vpipe     <= {vpipe[1:0], valid_in};
                valid_out <= vpipe[2];
            end
            if (accept) begin
                if (in_cnt == '0) begin
                    frame_mode <= mode;
                end
                in_cnt <= (in_cnt == LAST) ? '0 : in_cnt + CW'(1);
            end
            if (emit) begin
                out_cnt <= (out_cnt == LAST) ? '0 : out_cnt + CW'(1);
                done    <= (out_cnt == LAST);
            end
        end
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        cnn_act_lane #(
            .DATA_WIDTH (DATA_WIDTH),
            .FRAC_BITS  (FRAC_BITS)
        ) u_lane (
            .clk   (clk),
            .reset (reset),
            .en    (en),
            .mode  (beat_mode),
            .x     (in[i*DATA_WIDTH +: DATA_WIDTH]),
            .y     (out[i*DATA_WIDTH +: DATA_WIDTH])
        );
    end

endmodule

// File: tb/tb_cnn_activation.sv
// Randomized bench for cnn_activation: an integer reference model of the
// activation rules feeds a scoreboard; frame/done and stall behaviour tracked alongside.
module tb_cnn_activation;

    localparam int DW = 16;
    localparam int FB = 8;
    localparam int LN = 4;
    localparam int FL = 4;
    localparam int BW = LN * DW;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [1:0]    mode = 2'd0;
    logic          valid_in = 1'b0;
    logic          ready_in;
    logic [BW-1:0] in_data = '0;
    logic          valid_out;
    logic          ready_out = 1'b1;
    logic [BW-1:0] out_data;
    logic          done;

    always #5 clk = ~clk;

    cnn_activation #(
        .DATA_WIDTH (DW),
        .FRAC_BITS  (FB),
        .LANES      (LN),
        .FRAME_LEN  (FL)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .mode      (mode),
        .valid_in  (valid_in),
        .ready_in  (ready_in),
        .in        (in_data),
        .valid_out (valid_out),
        .ready_out (ready_out),
        .out       (out_data),
        .done      (done)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [BW-1:0] got, input logic [BW-1:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Reference model: sigma sampled at integers, linear in between.
    int s_pts[10] = '{32768, 47911, 57724, 62428, 64357, 65097, 65374, 65476, 65514, 65514};

    function automatic int act_ref(int x, int m);
        int xs, a, k, f, y;
        if (m == 2) return (x < 0) ? 0 : x;
        if (m == 3) return (x < 0) ? (x >>> 3) : x;
        xs = x;
        if (m == 1) begin
            xs = 2 * x;
            if (xs > 32767)  xs = 32767;
            if (xs < -32768) xs = -32768;
        end
        a = (xs < 0) ? -xs : xs;
        k = a >> FB;
        f = (a & ((1 << FB) - 1)) << (16 - FB);
        if (k >= 8) begin
            k = 8;
            f = 0;
        end
        y = s_pts[k] + ((s_pts[k+1] - s_pts[k]) * f) / 65536;
        if (xs < 0) y = 65536 - y;
        if (m == 1) y = 2 * y - 65536;
        return (y + (1 << (15 - FB))) >>> (16 - FB);
    endfunction

    function automatic logic [BW-1:0] pack_ref(input logic [BW-1:0] d, input int m);
        logic [BW-1:0] res;
        int x;
        res = '0;
        for (int i = 0; i < LN; i++) begin
            x = $signed(d[i*DW +: DW]);
            res[i*DW +: DW] = DW'(act_ref(x, m));
        end
        return res;
    endfunction

    function automatic logic [BW-1:0] rand_data();
        logic [BW-1:0] d;
        int v;
        for (int i = 0; i < LN; i++) begin
            if ($urandom_range(0, 1) == 0) v = int'($urandom_range(0, 65535));
            else v = int'($urandom_range(0, 6000)) - 3000;
            d[i*DW +: DW] = DW'(v);
        end
        return d;
    endfunction

    logic [BW-1:0] exp_q[$];
    int            cyc_q[$];
    int            icnt = 0;
    int            frame_m = 0;
    int            obeat = 0;
    bit            exp_done = 1'b0;
    bit            hold_chk = 1'b0;
    logic [BW-1:0] held = '0;
    int            dcount = 0;
    int            cyc = 0;
    int            rpol = 0;

    // One clock cycle: drive at the falling edge, then score what the next
    // rising edge will do with the settled handshake signals.
    task automatic step(input bit vin, input logic [1:0] m, input logic [BW-1:0] d,
                        input bit use_lit, input logic [BW-1:0] lit, output bit acc);
        @(negedge clk);
        cyc++;
        case (rpol)
            0:       ready_out = 1'b1;
            1:       ready_out = (cyc % 2 == 0);
            default: ready_out = ($urandom_range(0, 3) != 0);
        endcase
        valid_in = vin;
        mode     = m;
        in_data  = d;
        #1;
        check("done", done, exp_done);
        if (done) dcount++;
        if (hold_chk) begin
            check("hold_valid", valid_out, 1'b1);
            check("hold_out", out_data, held);
        end
        exp_done = 1'b0;
        if (valid_out && ready_out) begin
            if (exp_q.size() == 0) begin
                check("spurious_beat", valid_out, 1'b0);
            end else begin
                check("out", out_data, exp_q.pop_front());
                if (rpol == 0) check("latency", cyc - cyc_q[0], 4);
                void'(cyc_q.pop_front());
                obeat++;
                if (obeat % FL == 0) exp_done = 1'b1;
            end
        end
        hold_chk = valid_out && !ready_out;
        held     = out_data;
        acc = 1'b0;
        if (valid_in && ready_in) begin
            acc = 1'b1;
            if (icnt == 0) frame_m = m;
            exp_q.push_back(use_lit ? lit : pack_ref(d, frame_m));
            cyc_q.push_back(cyc);
            icnt = (icnt + 1) % FL;
        end
    endtask

    task automatic send(input logic [1:0] m, input logic [BW-1:0] d,
                        input bit use_lit, input logic [BW-1:0] lit);
        bit acc;
        int tries;
        tries = 0;
        do begin
            step(1'b1, m, d, use_lit, lit, acc);
            tries++;
        end while (!acc && tries < 20);
        if (!acc) check("accept_timeout", acc, 1'b1);
    endtask

    task automatic idle(input int n);
        bit acc;
        repeat (n) step(1'b0, 2'd0, '0, 1'b0, '0, acc);
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (exp_q.size() > 0 && t < 80) begin
            idle(1);
            t++;
        end
        check("drain_empty", exp_q.size(), 0);
        idle(2);
    endtask

    task automatic do_reset(input int n);
        @(negedge clk);
        reset    = 1'b0;
        valid_in = 1'b0;
        repeat (n) @(negedge clk);
        #1;
        check("rst_valid_out", valid_out, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_out", out_data, '0);
        reset = 1'b1;
        exp_q.delete();
        cyc_q.delete();
        icnt     = 0;
        obeat    = 0;
        exp_done = 1'b0;
        hold_chk = 1'b0;
        @(negedge clk);
        #1;
        check("rst_ready_in", ready_in, 1'b1);
    endtask

    task automatic pad_frame();
        while (icnt != 0) send(2'd0, rand_data(), 1'b0, '0);
    endtask

    initial begin
        do_reset(2);

        // Directed points, one frame per mode
        rpol = 0;
        send(2'd0, {16'h0800, 16'hFF00, 16'h0100, 16'h0000}, 1'b1,
                   {16'h0100, 16'h0045, 16'h00BB, 16'h0080});
        pad_frame();
        send(2'd1, {16'hFF80, 16'h0080, 16'hFF80, 16'h0080}, 1'b1,
                   {16'hFF8A, 16'h0076, 16'hFF8A, 16'h0076});
        pad_frame();
        send(2'd2, {16'h012C, 16'hFC80, 16'h012C, 16'hFC80}, 1'b1,
                   {16'h012C, 16'h0000, 16'h012C, 16'h0000});
        pad_frame();
        send(2'd3, {16'h012C, 16'hFC80, 16'h012C, 16'hFC80}, 1'b1,
                   {16'h012C, 16'hFF90, 16'h012C, 16'hFF90});
        pad_frame();
        drain();

        // Mode change mid-frame is ignored until the next frame
        send(2'd0, rand_data(), 1'b0, '0);
        send(2'd0, rand_data(), 1'b0, '0);
        send(2'd2, rand_data(), 1'b0, '0);
        send(2'd2, rand_data(), 1'b0, '0);
        for (int i = 0; i < FL; i++) send(2'd2, rand_data(), 1'b0, '0);
        drain();

        // Alternating backpressure over two frames
        rpol = 1;
        dcount = 0;
        for (int i = 0; i < 2 * FL; i++) send(2'd0, rand_data(), 1'b0, '0);
        drain();
        check("bp_done_count", dcount, 2);

        // Random modes, data, gaps and backpressure
        rpol = 2;
        for (int i = 0; i < 240; i++) begin
            if ($urandom_range(0, 3) == 0) idle(1);
            send(2'($urandom_range(0, 3)), rand_data(), 1'b0, '0);
        end
        drain();

        // Reset with beats in flight, then a fresh frame resamples mode
        rpol = 0;
        send(2'd0, {16'h0100, 16'h0100, 16'h0100, 16'h0100}, 1'b0, '0);
        send(2'd0, rand_data(), 1'b0, '0);
        send(2'd0, rand_data(), 1'b0, '0);
        idle(1);
        do_reset(1);
        dcount = 0;
        for (int i = 0; i < FL; i++) send(2'd2, rand_data(), 1'b0, '0);
        drain();
        idle(3);
        check("post_rst_done_once", dcount, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/cnn_activation.md
# cnn_activation

Parametrised, synthesizable activation unit for the CNN datapath; successor to the single-lane sigmoid stage. Applies sigmoid, tanh, ReLU or leaky-ReLU to LANES signed fixed-point values per beat, using piecewise-linear interpolation instead of simulation-only real arithmetic. It sits between the convolution/batch-norm output and the next layer's input buffer, with valid/ready backpressure and a per-frame done pulse.

## Interface
- DATA_WIDTH, 16: signed two's-complement sample width; must be ≥ FRAC_BITS+5.
- FRAC_BITS, 8: fractional bits of samples; range 1..16.
- LANES, 4: parallel channels per beat.
- FRAME_LEN, 1024: output beats per frame; ≥ 1.
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-low reset.
- mode  in  2  0 sigmoid, 1 tanh, 2 ReLU, 3 leaky-ReLU.
- valid_in  in  1  input beat valid.
- ready_in  out  1  unit can accept a beat.
- in  in  LANES*DATA_WIDTH  lane i at [i*DATA_WIDTH +: DATA_WIDTH].
- valid_out  out  1  output beat valid.
- ready_out  in  1  downstream accepts.
- out  out  LANES*DATA_WIDTH  same packing, same Q format as in.
- done  out  1  one-cycle pulse after the last beat of a frame is accepted.

## Operation
- Beat accepted on valid_in && ready_in; emitted on valid_out && ready_out.
- Mode sampled on the first accepted beat of a frame (input beat counter = 0), held until FRAME_LEN beats have been accepted; mode changes mid-frame are ignored.
- Sigmoid: a = |x|, k = integer part of a clamped to 8 (frac forced 0 when a ≥ 8), f = fractional part widened to 16 bits. y16 = S[k] + ((S[k+1]-S[k])*f >> 16), with S[9] = S[8]. S = Q0.16 table of σ(0..8): 32768, 47911, 57724, 62428, 64357, 65097, 65374, 65476, 65514. Negative x: y16 = 65536 - y16.
- Tanh: x' = 2x saturated to DATA_WIDTH; σ path on x'; result 2*y16 - 65536 (signed).
- ReLU: x<0 → 0, else x. Leaky: x<0 → x >>> 3 (arithmetic), else x.
- Sigmoid/tanh result converted Q16 → FRAC_BITS by round-half-up (add 1<<(15-FRAC_BITS), shift); never overflows given the DATA_WIDTH rule.
- All lanes processed identically and in lockstep.

## Timing
- 4-stage pipeline: S1 abs/sign/mode prep/index, S2 table lookup, S3 multiply-add, S4 symmetry/post/round into the out register. Latency 4 cycles from accept to valid_out with ready_out high. Throughput 1 beat/cycle.
- Global stall: enable = !valid_out || ready_out; ready_in = enable. When stalled, all stages hold and out/valid_out stay stable.
- ReLU/leaky use the same 4-cycle latency (bypass registers stage-aligned).
- Output beat counter increments on each output handshake; at FRAME_LEN-1 it wraps to 0 and done is high the following cycle for exactly one cycle. Back-to-back frames allowed with no bubble.
- Reset (reset low at a clock edge): all stage valids, valid_out, done, both counters cleared; out = 0; ready_in = 1 the cycle after release. Reset mid-frame discards in-flight beats; next accepted beat starts a new frame and resamples mode.

## Structure
- Package cnn_act_pkg: mode encoding constants, S table (9 entries, Q0.16), COEF_FRAC = 16, LEAKY_SHIFT = 3.
- Sub-module cnn_act_lane: one lane's 4-stage datapath with enable input; cnn_activation instantiates LANES copies plus shared valid pipeline, handshake, mode register, beat counters and done logic.

## Test plan
- DATA_WIDTH=16, FRAC_BITS=8, mode 0, lanes {0, +256, -256, +2048} → {128, 187, 69, 256} after 4 cycles (σ(8) rounds to 256).
- mode 1, lane x=+128 (0.5) → 118; x=-128 → -118.
- mode 2/3, x=-896 (-3.5) → 0 / -112; x=+300 → 300 in both.
- FRAME_LEN=4, 8 beats streamed with ready_out toggling 1,0 each cycle → no lost/duplicated beats, out stable while stalled, done pulses once after beat 4 and once after beat 8.
- Change mode from 0 to 2 after beat 2 of a frame → remaining beats of that frame still sigmoid; next frame ReLU.
- Assert reset low with 3 beats in flight → valid_out, done, out = 0 next cycle; after release, new frame of FRAME_LEN beats produces done exactly once.
